// File: rtl/cpu_pkg.sv
// Shared CPU definitions: timing phase indices, timing vector width and
// instruction register field positions.
package cpu_pkg;

  localparam int T_WIDTH = 12;

  localparam int T0  = 0;
  localparam int T1  = 1;
  localparam int T2  = 2;
  localparam int T3  = 3;
  localparam int T4  = 4;
  localparam int T5  = 5;
  localparam int T6  = 6;
  localparam int T7  = 7;
  localparam int T8  = 8;
  localparam int T9  = 9;
  localparam int T10 = 10;
  localparam int T11 = 11;

  // IR field positions (msb, lsb)
  localparam int OPCODE_MSB   = 15;
  localparam int OPCODE_LSB   = 10;
  localparam int DEST_MSB     = 9;
  localparam int DEST_LSB     = 7;
  localparam int SRC1_MSB     = 6;
  localparam int SRC1_LSB     = 4;
  localparam int SRC2_MSB     = 3;
  localparam int SRC2_LSB     = 1;
  localparam int REGSEL_MSB   = 9;
  localparam int REGSEL_LSB   = 8;
  localparam int ADDRESS_MSB  = 7;
  localparam int ADDRESS_LSB  = 0;

  function automatic logic is_fetch_phase(input logic [T_WIDTH-1:0] t);
    return t[T0] | t[T1];
  endfunction

endpackage

// File: rtl/sequence_counter.sv
// One-hot timing phase register. Clear wins over hold, hold wins over
// advance; advancing saturates at the last phase instead of wrapping.
module sequence_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::T_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             clear,
  input  logic             hold,
  output logic [WIDTH-1:0] t
);

  localparam logic [WIDTH-1:0] FIRST = WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t <= FIRST;
    end else if (clear) begin
      t <= FIRST;
    end else if (hold) begin
      t <= t;
    end else if (advance && !t[WIDTH-1]) begin
      t <= t << 1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Timing generator and two-byte instruction fetch: fetches low then high
// byte in T0/T1, then steps execute phases until the decoder ends the instruction.
//
// phase     | meaning
// T0        | fetch low byte, wait for Mem_Ack
// T1        | fetch high byte, wait for Mem_Ack
// T2..Tlast | execute, IR valid; Stall holds, T_Reset returns to T0
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int T_WIDTH = cpu_pkg::T_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [15:0]        PC,
  input  logic [7:0]         Mem_Data,
  input  logic               Mem_Ack,
  input  logic               T_Reset,
  input  logic               Stall,
  output logic               Mem_Req,
  output logic [15:0]        Mem_Addr,
  output logic               PC_Inc,
  output logic [T_WIDTH-1:0] T,
  output logic [15:0]        IROut,
  output logic               IR_Valid,
  output logic               Fetch_Err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          fetch;
  logic          execute;
  logic          accept;
  logic          waiting;
  logic          advance;
  logic          clear;
  logic [CW-1:0] wait_count;

  always_comb begin
    fetch    = T[T0] | T[T1];
    execute  = ~fetch;
    // Reset gating keeps the request quiet while the block is held in reset.
    Mem_Req  = fetch & ~Fetch_Err & Reset;
    PC_Inc   = Mem_Req & Mem_Ack;
    accept   = PC_Inc;
    waiting  = Mem_Req & ~Mem_Ack;
    advance  = accept | (execute & ~Stall);
    clear    = execute & T_Reset;
    IR_Valid = execute;
    Mem_Addr = PC;
  end

  sequence_counter #(
    .WIDTH(T_WIDTH)
  ) u_sequence_counter (
    .clock  (Clock),
    .reset  (Reset),
    .advance(advance),
    .clear  (clear),
    .hold   (Fetch_Err),
    .t      (T)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      IROut <= 16'h0000;
    end else if (accept) begin
      if (T[T0]) IROut[7:0]  <= Mem_Data;
      else       IROut[15:8] <= Mem_Data;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_count <= '0;
      Fetch_Err  <= 1'b0;
    end else if (accept) begin
      wait_count <= '0;
    end else if (waiting) begin
      wait_count <= wait_count + CW'(1);
      if (wait_count == CW'(TIMEOUT - 1)) Fetch_Err <= 1'b1;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Timing generator and two-byte instruction fetch unit for the CPU system. Produces the one-hot timing vector `T` and the 16-bit instruction register that the control decoder consumes. Fetches each instruction as two bytes (low byte, then high byte) from the 8-bit memory at the address held in PC. It then steps through the execute phases until the control decoder signals end-of-instruction with `T_Reset`.

## Interface
Parameters:
- `T_WIDTH`, 12: number of timing phases; one-hot width of `T`.
- `TIMEOUT`, 15: maximum number of cycles a fetch byte waits for `Mem_Ack` before a fault is flagged.

Ports:
- `Clock`  in  1  single system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `PC`  in  16  current program counter from the address register file.
- `Mem_Data`  in  8  memory read byte; valid when `Mem_Ack` is high.
- `Mem_Ack`  in  1  memory completes the current byte read this cycle.
- `T_Reset`  in  1  end of instruction from the control decoder.
- `Stall`  in  1  holds the execute phase.
- `Mem_Req`  out  1  byte read request.
- `Mem_Addr`  out  16  read address; always equal to `PC`.
- `PC_Inc`  out  1  one-cycle request to increment PC.
- `T`  out  `T_WIDTH`  one-hot timing vector.
- `IROut`  out  16  instruction register.
- `IR_Valid`  out  1  `IROut` holds a complete instruction.
- `Fetch_Err`  out  1  sticky fetch timeout flag.

## Operation
- **Reset values:** `T`=12'h001 (T0), `IROut`=16'h0000, `Fetch_Err`=0, timeout counter=0. While in reset, `Mem_Req`, `PC_Inc` and `IR_Valid` are 0.
- **Phase T0, low byte fetch:**
  - `Mem_Req`=1.
  - In a cycle with `Mem_Ack`=1, `Mem_Data` is written to `IROut[7:0]`, `PC_Inc`=1, and the next phase is T1.
- **Phase T1, high byte fetch:**
  - Same handshake as T0; the byte is written to `IROut[15:8]`, and the next phase is T2.
  - `IROut[15:8]` keeps the previous instruction's value until this capture.
- **Phases T2..T(T_WIDTH-1), execute:**
  - `Mem_Req`=0 and `IR_Valid`=1.
  - Advance one phase per cycle unless `Stall`=1.
  - The last phase holds until `T_Reset`.
- **`T_Reset` handling:**
  - In any execute phase, the next phase is T0. This has priority over `Stall` and over advancing.
  - During T0 or T1, `T_Reset` is ignored.
- **Output equations:**
  - `PC_Inc` = `Mem_Req` & `Mem_Ack` (combinational). The ARF increments PC on the same edge that captures the byte.
  - `Mem_Req` = (T0 | T1) & ~`Fetch_Err`.
  - `Mem_Ack` is ignored while `Mem_Req`=0.
- **Timeout:**
  - The counter increments each T0/T1 cycle that has `Mem_Req`=1 and `Mem_Ack`=0. It clears on an accepted byte.
  - When the counter reaches `TIMEOUT`, `Fetch_Err` is set. `T` freezes in its current phase, and `Mem_Req` and `PC_Inc` are forced to 0.
  - Only `Reset` clears `Fetch_Err`.
- **Invariant:** `T` is always exactly one-hot. The block never leaves the phase set.

## Timing
- Minimum fetch: 2 cycles. This requires `Mem_Ack` in the first cycle of both T0 and T1. T2 is reached on the third cycle after reset release.
- Each cycle of `Mem_Ack` delay adds one cycle to the affected fetch byte.
- `IROut` and `IR_Valid` update on the same edge that enters T2.
- `T_Reset` sampled high in phase Tk (k≥2) gives T0 on the next cycle. The next fetch's `Mem_Req` is high in that cycle.
- Reset asserted mid-fetch or mid-execute takes effect immediately (asynchronous). All state returns to reset values, and any partial byte is discarded.
- `Fetch_Err` rises on the edge that ends the `TIMEOUT`-th waiting cycle.

## Structure
- **Shared package `cpu_pkg`:**
  - Phase index constants `T0`..`T11`.
  - `T_WIDTH`.
  - IR field positions: opcode [15:10], DestReg [9:7], SrcReg1 [6:4], SrcReg2 [3:1], RegSel [9:8], Address [7:0].
- **Sub-module `sequence_counter`:**
  - One-hot `T` register with inputs `advance`, `clear` (T_Reset), `hold`.
  - Rotate-free: it saturates at the last phase.
  - Holds the fetch/execute gating and the timeout counter in the parent.

## Test plan
- **Reset, then immediate ack:** Release `Reset`, PC=16'h0010, `Mem_Ack` tied to 1, bytes 8'h34 then 8'h12. Required: `PC_Inc` high for 2 cycles, `T` goes 001→002→004, `IROut`=16'h1234, `IR_Valid`=1 at T2.
- **Delayed ack:** `Mem_Ack` arrives 3 cycles after `Mem_Req` on the low byte. Required: T stays in T0 for 4 cycles, exactly one `PC_Inc` pulse, and the total fetch takes 5 cycles.
- **Execute stepping:**
  - With `Stall`=1 in T4 for 2 cycles: T4 is held for 3 cycles.
  - No `T_Reset` issued: `T` saturates at 12'h800 and holds.
  - `T_Reset` asserted in T5: the next cycle is T0 with `Mem_Req`=1.
- **`T_Reset` during fetch:** Assert `T_Reset` in T1 with `Mem_Ack`=0. Required: it is ignored, and T1 is held until the ack.
- **Timeout:** `Mem_Ack` held at 0 in T0. Required: `Fetch_Err`=1 after 15 cycles, `Mem_Req`=0 thereafter, `T`=12'h001 frozen, and only `Reset` recovers.
- **Reset mid-instruction:** Drive `Reset` low in T6. Required: `T`=12'h001, `IROut`=0 and `IR_Valid`=0 immediately, without waiting for a clock edge.
